// File: rtl/tpm_host_arbiter_pkg.sv
// Shared definitions for the TPM host arbiter: FSM state encoding, requester
// port indices, bus widths and the default register-file acknowledge timeout.
package tpm_host_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Requester port indices
    localparam logic PORT_LPC = 1'b0;
    localparam logic PORT_SPI = 1'b1;

    // Cycles to wait for reg_ack_i before aborting an access
    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    // Read data returned when an access is aborted
    localparam logic [DATA_W-1:0] RDATA_TIMEOUT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tpm_host_arbiter_rr_arbiter.sv
// tpm_rr_arbiter: two-way round-robin grant with owner lock.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   eligible_i      per-port eligibility (txn active and a request pending)
//   lock_i          current owner still holds its transaction window
//   owner_i         current owner index
//   update_i        grant is being consumed this cycle; record it as last owner
//   grant_vld_o     a port may be served
//   grant_o         index of the port to serve
module tpm_rr_arbiter
    import tpm_host_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] eligible_i,
    input  logic       lock_i,
    input  logic       owner_i,
    input  logic       update_i,
    output logic       grant_vld_o,
    output logic       grant_o
);

    logic last_owner;

    always_comb begin
        grant_vld_o = 1'b0;
        grant_o     = owner_i;
        if (lock_i) begin
            // Locked: only the owner can be served, the other port waits
            grant_vld_o = eligible_i[owner_i];
            grant_o     = owner_i;
        end else begin
            grant_vld_o = |eligible_i;
            if (&eligible_i) begin
                grant_o = ~last_owner;
            end else if (eligible_i[PORT_SPI]) begin
                grant_o = PORT_SPI;
            end else begin
                grant_o = PORT_LPC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_owner <= PORT_SPI;
        end else if (update_i && grant_vld_o) begin
            last_owner <= grant_o;
        end
    end

endmodule

// File: rtl/tpm_host_arbiter.sv
// tpm_host_arbiter: shares one TPM register-file port between an LPC and an
// SPI requester. Ownership is granted round-robin and locked for the whole
// transaction window (txn_i) of the owner, so multi-byte accesses from one
// host are never interleaved with the other.
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   txn_i[p]                    requester transaction window (0=LPC, 1=SPI)
//   addr_i[p], wdata_i[p]       register address and write byte
//   wr_i[p], rd_i[p]            level requests, held until matching done
//   wr_done_o[p], rd_done_o[p]  level completions (4-phase handshake)
//   rdata_o[p]                  read byte, valid while rd_done_o[p] is high
//   reg_addr_o, reg_wdata_o     register-file address and write data
//   reg_we_o, reg_re_o          single-cycle write/read strobes
//   reg_rdata_i, reg_ack_i      register-file read data and acknowledge
//   owner_o, busy_o, err_o      current owner, lock held, sticky timeout
module tpm_host_arbiter
    import tpm_host_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [1:0]             txn_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    input  logic [1:0]             wr_i,
    input  logic [1:0]             rd_i,
    output logic [1:0]             wr_done_o,
    output logic [1:0]             rd_done_o,
    output logic [1:0][DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0]      reg_addr_o,
    output logic [DATA_W-1:0]      reg_wdata_o,
    output logic                   reg_we_o,
    output logic                   reg_re_o,
    input  logic [DATA_W-1:0]      reg_rdata_i,
    input  logic                   reg_ack_i,
    output logic                   owner_o,
    output logic                   busy_o,
    output logic                   err_o
);

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       op_rd;       // access in flight is a read
    logic [1:0] eligible;
    logic       lock;
    logic       grant_vld;
    logic       grant;
    logic       owner_req;   // owner still holds the request being served

    assign eligible  = txn_i & (wr_i | rd_i);
    assign lock      = busy_o & txn_i[owner_o];
    assign owner_req = op_rd ? rd_i[owner_o] : wr_i[owner_o];

    tpm_rr_arbiter u_rr_arbiter (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .eligible_i  (eligible),
        .lock_i      (lock),
        .owner_i     (owner_o),
        .update_i    (state == ST_IDLE),
        .grant_vld_o (grant_vld),
        .grant_o     (grant)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            op_rd       <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            owner_o     <= 1'b0;
            wr_done_o   <= '0;
            rd_done_o   <= '0;
            rdata_o     <= '0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
        end else begin
            // Strobes are only ever high for the single ISSUE cycle
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        busy_o      <= 1'b1;
                        owner_o     <= grant;
                        reg_addr_o  <= addr_i[grant];
                        reg_wdata_o <= wdata_i[grant];
                        // Read wins when both levels are up
                        op_rd       <= rd_i[grant];
                        reg_re_o    <= rd_i[grant];
                        reg_we_o    <= ~rd_i[grant];
                        state       <= ST_ISSUE;
                    end else if (!lock) begin
                        busy_o <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Ack is checked first so an ack on the timeout cycle is a normal completion
                    if (reg_ack_i || (tmo_cnt == TIMEOUT)) begin
                        if (op_rd) begin
                            rdata_o[owner_o] <= reg_ack_i ? reg_rdata_i : RDATA_TIMEOUT;
                        end
                        if (!reg_ack_i) begin
                            err_o <= 1'b1;
                        end
                        if (txn_i[owner_o]) begin
                            if (op_rd) begin
                                rd_done_o[owner_o] <= 1'b1;
                            end else begin
                                wr_done_o[owner_o] <= 1'b1;
                            end
                            state <= ST_DONE;
                        end else begin
                            // Owner abandoned its window: finish silently and drop the lock
                            busy_o <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    if (!owner_req || !txn_i[owner_o]) begin
                        wr_done_o <= '0;
                        rd_done_o <= '0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpm_host_arbiter.sv
module tb_tpm_host_arbiter;
    import tpm_host_arbiter_pkg::*;

    localparam int TMO = 255;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [1:0]       txn_i;
    logic [1:0][15:0] addr_i;
    logic [1:0][7:0]  wdata_i;
    logic [1:0]       wr_i;
    logic [1:0]       rd_i;
    logic [1:0]       wr_done_o;
    logic [1:0]       rd_done_o;
    logic [1:0][7:0]  rdata_o;
    logic [15:0]      reg_addr_o;
    logic [7:0]       reg_wdata_o;
    logic             reg_we_o;
    logic             reg_re_o;
    logic [7:0]       reg_rdata_i;
    logic             reg_ack_i;
    logic             owner_o;
    logic             busy_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;

    // Register-file stub
    logic [7:0]  mem [0:255];
    int          ack_delay = 0;   // WAIT cycle index carrying the ack; -1 = never
    int          ack_cnt   = 0;
    logic [15:0] pend_addr = '0;
    bit          prev_stb  = 1'b0;

    tpm_host_arbiter #(.TIMEOUT(8'd255)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .txn_i       (txn_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wr_i        (wr_i),
        .rd_i        (rd_i),
        .wr_done_o   (wr_done_o),
        .rd_done_o   (rd_done_o),
        .rdata_o     (rdata_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ack_i   (reg_ack_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] stub_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // Register-file model and strobe scoreboard, sampled on the falling edge
    always @(negedge clk_i) begin
        reg_ack_i = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) begin
                reg_ack_i   = 1'b1;
                reg_rdata_i = mem[pend_addr[7:0]];
            end
        end
        if (reg_we_o || reg_re_o) begin
            checks++;
            if (reg_we_o && reg_re_o) begin
                errors++;
                $display("FAIL strobe_exclusive: we=%0b re=%0b, required not both high", reg_we_o, reg_re_o);
            end
            checks++;
            if (prev_stb) begin
                errors++;
                $display("FAIL strobe_width: strobe high on consecutive cycles, required single-cycle pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL reg_access: unexpected strobe we=%0b addr=%h", reg_we_o, reg_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (reg_we_o !== mon_e.we || reg_addr_o !== mon_e.addr ||
                    (mon_e.we && reg_wdata_o !== mon_e.data)) begin
                    errors++;
                    $display("FAIL reg_access: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                             reg_we_o, reg_addr_o, reg_wdata_o, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
            if (reg_we_o) mem[reg_addr_o[7:0]] = reg_wdata_o;
            pend_addr = reg_addr_o;
            ack_cnt   = (ack_delay < 0) ? 0 : ack_delay + 1;
        end
        prev_stb = reg_we_o | reg_re_o;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_acc(input logic we, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{we: we, addr: a, data: d});
    endtask

    // One request/done handshake on port p; txn_i[p] is managed by the caller
    task automatic port_access(input int p, input bit is_rd, input logic [15:0] a,
                               input logic [7:0] d, input logic [7:0] exp_rd,
                               input int exp_lat, input int max_cyc);
        int lat;
        bit got;
        addr_i[p]  = a;
        wdata_i[p] = d;
        if (is_rd) rd_i[p] = 1'b1;
        else       wr_i[p] = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < max_cyc) begin
            @(posedge clk_i);
            #1;
            lat++;
            got = is_rd ? rd_done_o[p] : wr_done_o[p];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_wait port%0d addr=%h: no done within %0d cycles", p, a, lat);
        end else begin
            if (exp_lat > 0) begin
                checks++;
                if (lat !== exp_lat) begin
                    errors++;
                    $display("FAIL latency port%0d addr=%h: got %0d cycles, required %0d", p, a, lat, exp_lat);
                end
            end
            if (is_rd) begin
                checks++;
                if (rdata_o[p] !== exp_rd) begin
                    errors++;
                    $display("FAIL rdata port%0d addr=%h: got %h, required %h", p, a, rdata_o[p], exp_rd);
                end
            end
            checks++;
            if (owner_o !== 1'(p)) begin
                errors++;
                $display("FAIL owner port%0d: got %0b, required %0d", p, owner_o, p);
            end
        end
        rd_i[p] = 1'b0;
        wr_i[p] = 1'b0;
        cyc(1);
        checks++;
        if (rd_done_o[p] !== 1'b0 || wr_done_o[p] !== 1'b0) begin
            errors++;
            $display("FAIL done_release port%0d: rd_done=%0b wr_done=%0b, required 0", p, rd_done_o[p], wr_done_o[p]);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        cyc(3);
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0 || owner_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%0b err=%0b owner=%0b, required 0", busy_o, err_o, owner_o);
        end
        checks++;
        if (wr_done_o !== 2'b00 || rd_done_o !== 2'b00 || reg_we_o !== 1'b0 || reg_re_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: wr_done=%b rd_done=%b we=%0b re=%0b, required 0",
                     wr_done_o, rd_done_o, reg_we_o, reg_re_o);
        end
        checks++;
        if (rdata_o !== '0 || reg_addr_o !== 16'h0 || reg_wdata_o !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0", rdata_o, reg_addr_o, reg_wdata_o);
        end
        rst_n_i = 1'b1;
        cyc(1);
    endtask

    task automatic test_spi_write();
        ack_delay = 0;
        txn_i[1] = 1'b1;
        push_acc(1'b1, 16'h0018, 8'hA5);
        port_access(1, 1'b0, 16'h0018, 8'hA5, 8'h00, 3, 20);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_held: busy=%0b, required 1", busy_o);
        end
        push_acc(1'b0, 16'h0018, 8'h00);
        port_access(1, 1'b1, 16'h0018, 8'h00, 8'hA5, 3, 20);
        txn_i[1] = 1'b0;
        cyc(1);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: busy=%0b, required 0", busy_o);
        end
    endtask

    task automatic test_simultaneous();
        rst_n_i = 1'b0;
        cyc(2);
        rst_n_i = 1'b1;
        ack_delay = 0;
        push_acc(1'b0, 16'h0040, 8'h00);
        push_acc(1'b0, 16'h0041, 8'h00);
        fork
            begin
                txn_i[0] = 1'b1;
                port_access(0, 1'b1, 16'h0040, 8'h00, stub_byte(16'h0040), 3, 20);
                cyc(2);
                txn_i[0] = 1'b0;
            end
            begin
                txn_i[1] = 1'b1;
                port_access(1, 1'b1, 16'h0041, 8'h00, stub_byte(16'h0041), 0, 60);
                txn_i[1] = 1'b0;
            end
        join
        cyc(2);
    endtask

    task automatic test_back_to_back();
        ack_delay = 0;
        for (int k = 0; k < 4; k++) push_acc(1'b0, 16'h0100 + 16'(k), 8'h00);
        push_acc(1'b1, 16'h0050, 8'h5A);
        fork
            begin
                txn_i[1] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    port_access(1, 1'b1, 16'h0100 + 16'(k), 8'h00, stub_byte(16'h0100 + 16'(k)),
                                (k == 0) ? 3 : 0, 20);
                    cyc(2);
                end
                txn_i[1] = 1'b0;
            end
            begin
                cyc(1);
                txn_i[0] = 1'b1;
                port_access(0, 1'b0, 16'h0050, 8'h5A, 8'h00, 0, 100);
                txn_i[0] = 1'b0;
            end
        join
        cyc(2);
    endtask

    task automatic test_ack_boundary();
        ack_delay = TMO;
        txn_i[0] = 1'b1;
        push_acc(1'b0, 16'h0020, 8'h00);
        port_access(0, 1'b1, 16'h0020, 8'h00, stub_byte(16'h0020), TMO + 3, 400);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_timeout_err: err=%0b, required 0", err_o);
        end
        txn_i[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_timeout();
        ack_delay = -1;
        txn_i[0] = 1'b1;
        push_acc(1'b0, 16'h0021, 8'h00);
        port_access(0, 1'b1, 16'h0021, 8'h00, 8'hFF, TMO + 3, 400);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: err=%0b, required 1", err_o);
        end
        ack_delay = 0;
        push_acc(1'b0, 16'h0022, 8'h00);
        port_access(0, 1'b1, 16'h0022, 8'h00, stub_byte(16'h0022), 3, 20);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%0b, required 1", err_o);
        end
        txn_i[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_in_wait();
        ack_delay = -1;
        push_acc(1'b0, 16'h0030, 8'h00);
        txn_i[1]   = 1'b1;
        addr_i[1]  = 16'h0030;
        rd_i[1]    = 1'b1;
        cyc(5);
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%0b err=%0b, required 1 1", busy_o, err_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0 || owner_o !== 1'b0 || reg_we_o !== 1'b0 || reg_re_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_status: busy=%0b err=%0b owner=%0b we=%0b re=%0b, required 0",
                     busy_o, err_o, owner_o, reg_we_o, reg_re_o);
        end
        checks++;
        if (wr_done_o !== 2'b00 || rd_done_o !== 2'b00 || rdata_o !== '0 || reg_addr_o !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_data: wr_done=%b rd_done=%b rdata=%h addr=%h, required 0",
                     wr_done_o, rd_done_o, rdata_o, reg_addr_o);
        end
        txn_i[1] = 1'b0;
        rd_i[1]  = 1'b0;
        cyc(2);
        rst_n_i   = 1'b1;
        ack_delay = 0;
        txn_i[0]  = 1'b1;
        push_acc(1'b1, 16'h0070, 8'h11);
        port_access(0, 1'b0, 16'h0070, 8'h11, 8'h00, 3, 20);
        txn_i[0] = 1'b0;
        cyc(2);
    endtask

    task automatic test_txn_drop();
        bit spi_done_seen;
        bit busy_low_seen;
        ack_delay = 4;
        push_acc(1'b1, 16'h0060, 8'h77);
        push_acc(1'b0, 16'h0061, 8'h00);
        spi_done_seen = 1'b0;
        busy_low_seen = 1'b0;
        fork
            begin
                txn_i[1]   = 1'b1;
                addr_i[1]  = 16'h0060;
                wdata_i[1] = 8'h77;
                wr_i[1]    = 1'b1;
                cyc(3);
                txn_i[1] = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    cyc(1);
                    if (wr_done_o[1]) spi_done_seen = 1'b1;
                    if (!busy_o) busy_low_seen = 1'b1;
                end
                wr_i[1] = 1'b0;
            end
            begin
                cyc(1);
                txn_i[0] = 1'b1;
                port_access(0, 1'b1, 16'h0061, 8'h00, stub_byte(16'h0061), 0, 60);
                txn_i[0] = 1'b0;
            end
        join
        checks++;
        if (spi_done_seen) begin
            errors++;
            $display("FAIL drop_done_suppressed: wr_done[1] seen=1, required 0");
        end
        checks++;
        if (!busy_low_seen) begin
            errors++;
            $display("FAIL drop_lock_release: busy low seen=0, required 1");
        end
        cyc(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        rst_n_i     = 1'b0;
        txn_i       = '0;
        addr_i      = '0;
        wdata_i     = '0;
        wr_i        = '0;
        rd_i        = '0;
        reg_rdata_i = '0;
        reg_ack_i   = 1'b0;

        test_reset();
        test_spi_write();
        test_simultaneous();
        test_back_to_back();
        test_ack_boundary();
        test_timeout();
        test_reset_in_wait();
        test_txn_drop();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_accesses: %0d expected register accesses never seen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
